// File: rtl/spi_master_sync.sv
// Synchronous SPI master: SCLK is a divided, registered copy of clk, so every
// SPI event lines up with a single clk edge. Frame length, mode and divider are per transaction.
module spi_master_sync #(
    parameter int SLAVE_COUNT = 8,
    parameter int MAX_BITS    = 32,
    parameter int DIV_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    input  logic [MAX_BITS-1:0]            tx_data,
    output logic [MAX_BITS-1:0]            rx_data,
    input  logic [$clog2(MAX_BITS)-1:0]    len_m1,
    input  logic [$clog2(SLAVE_COUNT)-1:0] chip_addr,
    input  logic [DIV_WIDTH-1:0]           clk_div,
    input  logic                           cpol,
    input  logic                           cpha,
    input  logic                           lsb_first,
    input  logic                           default_val,
    output logic                           SCLK,
    output logic                           MOSI,
    input  logic                           MISO,
    output logic [SLAVE_COUNT-1:0]         CS
);
    localparam int LW = $clog2(MAX_BITS);
    localparam int EW = LW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
    logic [EW-1:0]        edge_q, edge_d;
    logic [MAX_BITS-1:0]  tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [LW-1:0]        len_q, len_d;
    logic                 cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, dflt_q, dflt_d;
    logic                 sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;
    logic [SLAVE_COUNT-1:0] cs_q, cs_d, cs_sel_n;

    logic [LW-1:0] len_in, half_idx, mosi_idx, rx_pos;
    logic          half_end, lead_edge, last_edge, sample_edge, shift_edge;

    // Position in the data word of the k-th bit on the wire.
    function automatic logic tx_bit(input logic [MAX_BITS-1:0] data, input logic [LW-1:0] len,
                                    input logic lsb, input logic [LW-1:0] k);
        logic [LW-1:0] pos;
        pos = lsb ? k : len - k;
        return data[pos];
    endfunction

    assign len_in = (int'(len_m1) > MAX_BITS - 1) ? LW'(MAX_BITS - 1) : len_m1;

    // Out-of-range addresses decode to no select at all.
    for (genvar gi = 0; gi < SLAVE_COUNT; gi++) begin : g_cs_decode
        assign cs_sel_n[gi] = (int'(chip_addr) != gi);
    end

    // edge_q counts SCLK edges already produced, so edge_q[0]==0 means the next one is leading.
    assign half_end    = (cnt_q == div_q);
    assign half_idx    = edge_q[EW-1:1];
    assign mosi_idx    = cpha_q ? half_idx : half_idx + 1'b1;
    assign rx_pos      = lsb_q ? half_idx : len_q - half_idx;
    assign lead_edge   = ~edge_q[0];
    assign last_edge   = (edge_q == {len_q, 1'b1});
    assign sample_edge = cpha_q ? ~lead_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : (~lead_edge & ~last_edge);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        len_d     = len_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        dflt_d    = dflt_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_d      = cs_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    edge_d  = '0;
                    tx_d    = tx_data;
                    len_d   = len_in;
                    div_d   = clk_div;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    dflt_d  = default_val;
                    sclk_d  = cpol;
                    cs_d    = cs_sel_n;
                    rx_sh_d = '0;
                    mosi_d  = cpha ? default_val : tx_bit(tx_data, len_in, lsb_first, '0);
                end
            end
            SETUP: begin
                if (half_end) begin
                    state_d = XFER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            XFER: begin
                if (half_end) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    if (sample_edge) rx_sh_d[rx_pos] = MISO;
                    if (shift_edge) mosi_d = tx_bit(tx_q, len_q, lsb_q, mosi_idx);
                    if (last_edge) begin
                        state_d = HOLD;
                        edge_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (half_end) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    cs_d      = '1;
                    mosi_d    = dflt_q;
                    rx_data_d = rx_sh_q;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            len_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            dflt_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= '1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            len_q     <= len_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            dflt_q    <= dflt_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_q      <= cs_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign SCLK    = sclk_q;
    assign MOSI    = mosi_q;
    assign CS      = cs_q;
endmodule

// File: tb/tb_spi_master_sync.sv
// Directed bench for spi_master_sync (6 slaves, 32-bit frames): a cycle monitor
// measures busy length, CS, SCLK edges and the wire bit stream; a slave model drives MISO.
module tb_spi_master_sync;
    logic        clk = 1'b0;
    logic        rst, start, busy, done;
    logic [31:0] tx_data, rx_data;
    logic [4:0]  len_m1;
    logic [2:0]  chip_addr;
    logic [7:0]  clk_div;
    logic        cpol, cpha, lsb_first, default_val;
    logic        SCLK, MOSI, MISO;
    logic [5:0]  CS;

    logic        loopback, slave_bit, slave_lsb;
    logic [31:0] slave_w;
    int          slave_idx, slave_n;

    int          checks = 0;
    int          errors = 0;
    int          m_busy, m_cs_low, m_cs_bad, m_rise, m_period;
    logic        m_done, m_done_after, m_setup_mosi, m_setup_sclk, m_idle_sclk;
    logic [31:0] m_rx, m_mosi_word;

    assign MISO = loopback ? MOSI : slave_bit;

    spi_master_sync #(.SLAVE_COUNT(6), .MAX_BITS(32), .DIV_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .tx_data(tx_data), .rx_data(rx_data), .len_m1(len_m1), .chip_addr(chip_addr),
        .clk_div(clk_div), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .default_val(default_val), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS(CS)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic slave_update();
        if (slave_idx < slave_n)
            slave_bit = slave_w[slave_lsb ? slave_idx : slave_n - 1 - slave_idx];
        else
            slave_bit = 1'b0;
    endtask

    task automatic run_xfer(input logic [31:0] tx, input int n, input logic [2:0] addr,
                            input logic [7:0] div, input logic pol, input logic pha,
                            input logic lsb, input logic dv, input logic lb,
                            input logic [31:0] sw, input int glitch_at, input int rst_at);
        int   cyc, edges, samples, first_rise;
        logic prev_sclk, finished;
        tx_data = tx; len_m1 = 5'(n - 1); chip_addr = addr; clk_div = div;
        cpol = pol; cpha = pha; lsb_first = lsb; default_val = dv;
        loopback = lb; slave_w = sw; slave_n = n; slave_lsb = lsb; slave_idx = 0;
        slave_update();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tx_data = ~tx; len_m1 = ~len_m1; chip_addr = ~addr; clk_div = ~div;
        cpol = ~pol; cpha = ~pha; lsb_first = ~lsb; default_val = ~dv;
        m_busy = 0; m_cs_low = 0; m_cs_bad = 0; m_rise = 0; m_period = 0;
        m_mosi_word = '0; m_done = 1'b0; m_rx = '0; m_idle_sclk = 1'b0;
        m_setup_mosi = MOSI; m_setup_sclk = SCLK; prev_sclk = SCLK;
        edges = 0; samples = 0; first_rise = 0; cyc = 0; finished = 1'b0;
        while (!finished && cyc < 5000) begin
            if (cyc == rst_at) begin
                rst = 1'b0; #1;
                check_val("rst_cs", CS, 6'h3F);
                check_val("rst_sclk", SCLK, 0);
                check_val("rst_mosi", MOSI, 0);
                check_val("rst_busy", busy, 0);
                check_val("rst_rx", rx_data, 0);
                m_done = done;
                #2; rst = 1'b1;
                finished = 1'b1;
            end else if (busy) begin
                m_busy++;
                for (int i = 0; i < 6; i++)
                    if (!CS[i]) begin
                        if (i == int'(addr)) m_cs_low++;
                        else m_cs_bad++;
                    end
                if (SCLK != prev_sclk) begin
                    edges++;
                    if (SCLK) begin
                        m_rise++;
                        if (m_rise == 1) first_rise = cyc;
                        else if (m_rise == 2) m_period = cyc - first_rise;
                    end
                    if ((pha && edges % 2 == 0) || (!pha && edges % 2 == 1)) begin
                        m_mosi_word[lsb ? samples : n - 1 - samples] = MOSI;
                        samples++;
                        slave_idx = samples;
                        slave_update();
                    end
                end
                prev_sclk = SCLK;
            end else begin
                m_done = done; m_rx = rx_data; m_idle_sclk = SCLK;
                finished = 1'b1;
            end
            start = (cyc == glitch_at);
            if (start) tx_data = 32'h0F0F0F0F;
            if (!finished) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!finished) check_val("timeout", 1, 0);
        @(posedge clk); #1;
        m_done_after = done;
        $display("xfer tx=%h n=%0d cpol=%0d cpha=%0d lsb=%0d addr=%0d busy=%0d rx=%h",
                 tx, n, pol, pha, lsb, addr, m_busy, m_rx);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; tx_data = '0; len_m1 = '0; chip_addr = '0; clk_div = '0;
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; default_val = 1'b0;
        loopback = 1'b0; slave_bit = 1'b0; slave_w = '0; slave_idx = 0; slave_n = 0; slave_lsb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_cs", CS, 6'h3F);
        check_val("reset_sclk", SCLK, 0);
        check_val("reset_mosi", MOSI, 0);
        check_val("reset_rx", rx_data, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Mode 0, N=8, T=1, loopback: busy (2*8+2)*1 = 18
        run_xfer(32'hA5, 8, 3'd2, 8'd0, 0, 0, 0, 0, 1, 32'h0, -1, -1);
        check_val("m0_busy", m_busy, 18);
        check_val("m0_cs_low", m_cs_low, 18);
        check_val("m0_cs_other", m_cs_bad, 0);
        check_val("m0_rise", m_rise, 8);
        check_val("m0_rx", m_rx, 32'hA5);
        check_val("m0_mosi", m_mosi_word, 32'hA5);
        check_val("m0_setup_mosi", m_setup_mosi, 1);
        check_val("m0_done", m_done, 1);
        check_val("m0_done_pulse", m_done_after, 0);

        // Mode 3, N=16, T=2, LSB first, slave returns 0xBEEF
        run_xfer(32'h1234, 16, 3'd1, 8'd1, 1, 1, 1, 1, 0, 32'hBEEF, -1, -1);
        check_val("m3_busy", m_busy, 68);
        check_val("m3_rx", m_rx, 32'hBEEF);
        check_val("m3_mosi", m_mosi_word, 32'h1234);
        check_val("m3_setup_sclk", m_setup_sclk, 1);
        check_val("m3_idle_sclk", m_idle_sclk, 1);
        check_val("m3_setup_mosi", m_setup_mosi, 1);
        check_val("m3_rise", m_rise, 16);

        // Mode 1, N=32, T=4: busy 66*4 = 264, SCLK period 8
        run_xfer(32'hDEADBEEF, 32, 3'd4, 8'd3, 0, 1, 0, 0, 1, 32'h0, -1, -1);
        check_val("m1_busy", m_busy, 264);
        check_val("m1_period", m_period, 8);
        check_val("m1_rx", m_rx, 32'hDEADBEEF);
        check_val("m1_setup_mosi", m_setup_mosi, 0);
        check_val("m1_cs_low", m_cs_low, 264);

        // Mode 2, N=32, T=4
        run_xfer(32'hDEADBEEF, 32, 3'd5, 8'd3, 1, 0, 0, 1, 1, 32'h0, -1, -1);
        check_val("m2_busy", m_busy, 264);
        check_val("m2_period", m_period, 8);
        check_val("m2_rx", m_rx, 32'hDEADBEEF);
        check_val("m2_setup_mosi", m_setup_mosi, 1);
        check_val("m2_idle_sclk", m_idle_sclk, 1);

        // N=1, T=3: busy 4*3 = 12
        run_xfer(32'h1, 1, 3'd0, 8'd2, 0, 0, 0, 0, 0, 32'h1, -1, -1);
        check_val("n1_busy", m_busy, 12);
        check_val("n1_rx", m_rx, 32'h1);
        check_val("n1_done", m_done, 1);
        check_val("n1_done_pulse", m_done_after, 0);
        check_val("n1_rise", m_rise, 1);

        // start pulsed mid-frame with other data must be ignored
        run_xfer(32'h3C, 8, 3'd3, 8'd1, 0, 0, 0, 0, 1, 32'h0, 5, -1);
        check_val("gl_busy", m_busy, 36);
        check_val("gl_rx", m_rx, 32'h3C);
        check_val("gl_mosi", m_mosi_word, 32'h3C);

        // reset halfway through a 24-bit frame
        run_xfer(32'hABCDEF, 24, 3'd2, 8'd0, 0, 0, 0, 0, 1, 32'h0, -1, 25);
        check_val("rs_busy_seen", m_busy, 25);
        check_val("rs_no_done", m_done, 0);
        check_val("rs_no_done_after", m_done_after, 0);

        run_xfer(32'h123456, 24, 3'd2, 8'd0, 0, 0, 0, 0, 1, 32'h0, -1, -1);
        check_val("ar_busy", m_busy, 50);
        check_val("ar_rx", m_rx, 32'h123456);
        check_val("ar_done", m_done, 1);

        // chip_addr beyond SLAVE_COUNT: no select, same timing
        run_xfer(32'h5A, 8, 3'd7, 8'd0, 0, 0, 0, 0, 1, 32'h0, -1, -1);
        check_val("oob_cs_low", m_cs_low, 0);
        check_val("oob_cs_other", m_cs_bad, 0);
        check_val("oob_busy", m_busy, 18);
        check_val("oob_done", m_done, 1);
        check_val("oob_rx", m_rx, 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
